// File: rtl/panda_pkg.sv
// Shared decode types for the Panda execute stage.
package panda_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

endpackage

// File: rtl/panda_divider.sv
// Iterative RV32M divide unit: restoring shift-subtract, one quotient bit per cycle.
// Special cases (divide by zero, signed overflow) bypass iteration and finish in DONE.
module panda_divider
  import panda_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] dividend_i,
  input  logic [Width-1:0] divisor_i,
  input  logic             kill_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [Width-1:0] result_o
);

  localparam int unsigned CntW = $clog2(Width);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  div_op_e          op_q, op_sel;
  logic [Width-1:0] acc_q;     // dividend magnitude, shifts out MSB-first while quotient bits shift in
  logic [Width-1:0] div_q;
  logic [Width-1:0] rem_q;
  logic [Width-1:0] result_q;
  logic             neg_quo_q, neg_rem_q, valid_q;
  logic [CntW-1:0]  cnt_q;

  logic             is_signed, a_neg, b_neg, div_zero, overflow, special;
  logic [Width-1:0] a_mag, b_mag, quo_fix, rem_fix;
  logic [Width:0]   partial, diff;
  logic             ge;

  assign op_sel    = div_op_e'(op_i);
  assign is_signed = (op_sel == DIV) || (op_sel == REM);
  assign a_neg     = is_signed && dividend_i[Width-1];
  assign b_neg     = is_signed && divisor_i[Width-1];
  assign a_mag     = a_neg ? ('0 - dividend_i) : dividend_i;
  assign b_mag     = b_neg ? ('0 - divisor_i) : divisor_i;
  assign div_zero  = (divisor_i == '0);
  assign overflow  = is_signed && (dividend_i == {1'b1, {(Width-1){1'b0}}}) && (divisor_i == '1);
  assign special   = div_zero || overflow;

  // Partial remainder is always < 2*divisor, so the borrow bit alone decides partial >= divisor.
  assign partial   = {rem_q, acc_q[Width-1]};
  assign diff      = partial - {1'b0, div_q};
  assign ge        = ~diff[Width];

  assign quo_fix   = neg_quo_q ? ('0 - acc_q) : acc_q;
  assign rem_fix   = neg_rem_q ? ('0 - rem_q) : rem_q;

  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start_i) state_d = special ? DONE : CALC;
        CALC:    if (cnt_q == '0) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= DIV;
      acc_q     <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= 1'b0;
      if (!kill_i) begin
        unique case (state_q)
          IDLE: begin
            if (start_i) begin
              op_q  <= op_sel;
              cnt_q <= CntW'(Width - 1);
              div_q <= b_mag;
              if (div_zero) begin
                acc_q     <= '1;
                rem_q     <= dividend_i;
                neg_quo_q <= 1'b0;
                neg_rem_q <= 1'b0;
              end else if (overflow) begin
                acc_q     <= {1'b1, {(Width-1){1'b0}}};
                rem_q     <= '0;
                neg_quo_q <= 1'b0;
                neg_rem_q <= 1'b0;
              end else begin
                acc_q     <= a_mag;
                rem_q     <= '0;
                neg_quo_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
              end
            end
          end
          CALC: begin
            rem_q <= ge ? diff[Width-1:0] : partial[Width-1:0];
            acc_q <= {acc_q[Width-2:0], ge};
            cnt_q <= cnt_q - CntW'(1);
          end
          DONE: begin
            valid_q  <= 1'b1;
            result_q <= ((op_q == DIV) || (op_q == DIVU)) ? quo_fix : rem_fix;
          end
          default: ;
        endcase
      end
    end
  end

  // The result cycle still stalls the pipeline, so busy covers the valid pulse too.
  assign busy_o   = (state_q != IDLE) || valid_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_panda_divider.sv
// Self-checking bench for panda_divider: directed cases plus randomized ops against an arithmetic model.
module tb_panda_divider;
  import panda_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic        busy, valid;
  logic [31:0] result;

  int passed = 0;
  int total  = 0;

  panda_divider #(.Width(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .op_i       (op),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .kill_i     (kill),
    .busy_o     (busy),
    .valid_o    (valid),
    .result_o   (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return (o == DIV || o == DIVU) ? 32'hFFFF_FFFF : a;
    if ((o == DIV || o == REM) && a == 32'h8000_0000 && sb == -1)
      return (o == DIV) ? 32'h8000_0000 : 32'h0;
    case (o)
      DIV:     return 32'(sa / sb);
      DIVU:    return a / b;
      REM:     return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || ((o == DIV || o == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic rand_operands(output logic [1:0] o, output logic [31:0] a, output logic [31:0] b);
    o = 2'($urandom_range(0, 3));
    a = $urandom;
    b = $urandom;
    case ($urandom_range(0, 5))
      0: b = 32'd0;
      1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      2: b = 32'($urandom_range(1, 15));
      3: b = b >> $urandom_range(0, 31);
      4: begin a = 32'($urandom_range(0, 1000)); b = -32'($urandom_range(1, 50)); end
      default: ;
    endcase
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else passed++;
    total++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [1:0]  ops [5] = '{DIV, REM, DIVU, REMU, DIV};
    logic [31:0] as  [5] = '{32'd100, -32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -32'd7};
    logic [31:0] bs  [5] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd2};
    logic [31:0] exp [5] = '{32'd14, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFD};
    int n;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i]);
      total++; if (busy !== 1'b1) $display("FAIL dir%0d_busy_start: got %b expected 1", i, busy); else passed++;
      wait_valid(n);
      total++; if (n !== 33) $display("FAIL dir%0d_latency: got %0d expected 33", i, n); else passed++;
      total++; if (result !== exp[i]) $display("FAIL dir%0d_result: got %h expected %h", i, result, exp[i]); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL dir%0d_busy_valid: got %b expected 1", i, busy); else passed++;
      @(posedge clk); #1;
      total++; if (valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL dir%0d_after: got valid=%b busy=%b expected 0 0", i, valid, busy); else passed++;
    end
  endtask

  task automatic test_special;
    logic [1:0]  ops [4] = '{DIV, REMU, DIV, REM};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int n;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_valid(n);
      total++; if (n !== 1) $display("FAIL spec%0d_latency: got %0d expected 1", i, n); else passed++;
      total++; if (result !== exp[i]) $display("FAIL spec%0d_result: got %h expected %h", i, result, exp[i]); else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a, b, e;
    int n, lat;
    for (int i = 0; i < 40; i++) begin
      rand_operands(o, a, b);
      e   = ref_div(o, a, b);
      lat = is_special(o, a, b) ? 1 : 33;
      issue(o, a, b);
      wait_valid(n);
      total++; if (n !== lat) $display("FAIL rand%0d_latency: got %0d expected %0d", i, n, lat); else passed++;
      total++; if (result !== e)
        $display("FAIL rand%0d_result op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, result, e); else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_kill;
    int n;
    issue(DIVU, 32'd1000, 32'd10);
    wait_valid(n);
    total++; if (result !== 32'd100) $display("FAIL kill_pre: got %h expected %h", result, 32'd100); else passed++;
    @(posedge clk); #1;
    issue(DIV, 32'd123456, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL kill_busy: got %b expected 0", busy); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL kill_valid: got %b expected 0", valid); else passed++;
    total++; if (result !== 32'd100) $display("FAIL kill_result_held: got %h expected %h", result, 32'd100); else passed++;
    issue(DIVU, 32'd9, 32'd3);
    wait_valid(n);
    total++; if (n !== 33) $display("FAIL kill_next_latency: got %0d expected 33", n); else passed++;
    total++; if (result !== 32'd3) $display("FAIL kill_next_result: got %h expected 3", result); else passed++;
    @(posedge clk); #1;
    // kill beats start in the same cycle
    kill = 1'b1;
    issue(DIVU, 32'd50, 32'd5);
    kill = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL kill_over_start: got busy=%b expected 0", busy); else passed++;
  endtask

  task automatic test_start_ignored;
    logic [1:0]  o, ro;
    logic [31:0] a, b, ra, rb, e;
    int n;
    o = DIV; a = -32'd100000; b = 32'd37;
    e = ref_div(o, a, b);
    issue(o, a, b);
    n = 0;
    while (valid !== 1'b1 && n < 200) begin
      rand_operands(ro, ra, rb);
      start = 1'b1; op = ro; dividend = ra; divisor = rb;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    total++; if (n !== 33) $display("FAIL ignore_latency: got %0d expected 33", n); else passed++;
    total++; if (result !== e) $display("FAIL ignore_result: got %h expected %h", result, e); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int pulses;
    issue(REMU, 32'hDEAD_BEEF, 32'd1234);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", valid); else passed++;
    total++; if (result !== 32'h0) $display("FAIL rstmid_result: got %h expected 00000000", result); else passed++;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) $display("FAIL rstmid_no_pulse: got %0d pulses expected 0", pulses); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [1:0]  o;
    logic [31:0] a, b, e;
    int n;
    for (int i = 0; i < 4; i++) begin
      o = (i % 2 == 0) ? DIVU : REM;
      a = $urandom;
      b = 32'($urandom_range(1, 100000));
      e = ref_div(o, a, b);
      issue(o, a, b);
      wait_valid(n);
      total++; if (n !== 33) $display("FAIL b2b%0d_latency: got %0d expected 33", i, n); else passed++;
      total++; if (result !== e) $display("FAIL b2b%0d_result: got %h expected %h", i, result, e); else passed++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; kill = 1'b0;
    op = DIV; dividend = '0; divisor = '0;
    @(posedge clk); #1;
    test_reset;
    test_directed;
    test_special;
    test_random;
    test_kill;
    test_start_ignored;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
